// File: rtl/up_reg_bank_pkg.sv
// Shared definitions for the up_reg_bank register slave: word indices of the
// register map and the interrupt-width legality check.
package up_reg_bank_pkg;

    localparam int REG_ID          = 0;
    localparam int REG_SCRATCH     = 1;
    localparam int REG_CONTROL     = 2;
    localparam int REG_STATUS      = 3;
    localparam int REG_IRQ_PENDING = 4;
    localparam int REG_IRQ_ENABLE  = 5;

    function automatic bit irq_width_valid(input int irq_width, input int bus_width);
        return (irq_width >= 1) && (irq_width <= bus_width * 8);
    endfunction

endpackage

// File: rtl/up_irq_ctrl.sv
// Interrupt controller for up_reg_bank: rising-edge capture into pending bits,
// write-1-to-clear, enable mask and a registered level interrupt.
module up_irq_ctrl #(
    parameter int IRQ_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_WIDTH-1:0] irq_src,
    input  logic                 w1c_we,
    input  logic [IRQ_WIDTH-1:0] w1c_data,
    input  logic                 en_we,
    input  logic [IRQ_WIDTH-1:0] en_data,
    output logic [IRQ_WIDTH-1:0] pending,
    output logic [IRQ_WIDTH-1:0] enable,
    output logic                 irq
);

    logic [IRQ_WIDTH-1:0] src_q;
    logic [IRQ_WIDTH-1:0] rise;
    logic [IRQ_WIDTH-1:0] clr;

    always_comb begin
        rise = irq_src & ~src_q;
        clr  = w1c_we ? w1c_data : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            enable  <= '0;
            irq     <= 1'b0;
        end else begin
            src_q   <= irq_src;
            // OR-ing the new edges after the clear lets a same-cycle set win.
            pending <= (pending & ~clr) | rise;
            if (en_we) begin
                enable <= en_data;
            end
            irq <= |(pending & enable);
        end
    end

endmodule

// File: rtl/up_reg_bank.sv
// uP request/acknowledge register bank: ID, scratch, control, status and
// (with UP_REG_BANK_IRQ_EN defined) interrupt pending/enable registers.
module up_reg_bank
    import up_reg_bank_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 16,
    parameter int          BUS_WIDTH     = 4,
    parameter logic [31:0] ID_VALUE      = 32'h0000_0001,
    parameter int          IRQ_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_rreq,
    output logic                     up_rack,
    input  logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [BUS_WIDTH*8-1:0]   up_rdata,
    input  logic                     up_wreq,
    output logic                     up_wack,
    input  logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  logic [BUS_WIDTH*8-1:0]   up_wdata,
    output logic [BUS_WIDTH*8-1:0]   ctrl,
    input  logic [BUS_WIDTH*8-1:0]   status,
    input  logic [IRQ_WIDTH-1:0]     irq_src,
    output logic                     irq
);

    localparam int DATA_W   = BUS_WIDTH * 8;
    localparam int ADDR_LSB = $clog2(BUS_WIDTH);

    if (!irq_width_valid(IRQ_WIDTH, BUS_WIDTH)) begin : g_irq_width_check
        $error("up_reg_bank: IRQ_WIDTH must lie in 1..BUS_WIDTH*8");
    end

    logic [ADDRESS_WIDTH-1:0] r_idx;
    logic [ADDRESS_WIDTH-1:0] w_idx;
    logic                     rd_acc;
    logic                     wr_acc;
    logic [DATA_W-1:0]        scratch_q;
    logic [DATA_W-1:0]        control_q;
    logic [DATA_W-1:0]        rd_mux;

    assign r_idx  = up_raddr >> ADDR_LSB;
    assign w_idx  = up_waddr >> ADDR_LSB;
    // A request seen while its own ack is high is the lingering upstream one.
    assign rd_acc = up_rreq && !up_rack;
    assign wr_acc = up_wreq && !up_wack;
    assign ctrl   = control_q;

`ifdef UP_REG_BANK_IRQ_EN
    logic                 irq_w1c_we;
    logic                 irq_en_we;
    logic [IRQ_WIDTH-1:0] irq_pending;
    logic [IRQ_WIDTH-1:0] irq_enable;

    assign irq_w1c_we = wr_acc && (w_idx == ADDRESS_WIDTH'(REG_IRQ_PENDING));
    assign irq_en_we  = wr_acc && (w_idx == ADDRESS_WIDTH'(REG_IRQ_ENABLE));

    up_irq_ctrl #(
        .IRQ_WIDTH (IRQ_WIDTH)
    ) u_irq_ctrl (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .w1c_we   (irq_w1c_we),
        .w1c_data (up_wdata[IRQ_WIDTH-1:0]),
        .en_we    (irq_en_we),
        .en_data  (up_wdata[IRQ_WIDTH-1:0]),
        .pending  (irq_pending),
        .enable   (irq_enable),
        .irq      (irq)
    );
`else
    logic unused_irq_src;

    assign unused_irq_src = ^irq_src;
    assign irq            = 1'b0;
`endif

    // NOTE: the mux reads the current register outputs, so a write accepted on
    // the same edge is not yet visible and the read returns the pre-write value.
    always_comb begin
        rd_mux = '0;
        case (r_idx)
            ADDRESS_WIDTH'(REG_ID):          rd_mux = DATA_W'(ID_VALUE);
            ADDRESS_WIDTH'(REG_SCRATCH):     rd_mux = scratch_q;
            ADDRESS_WIDTH'(REG_CONTROL):     rd_mux = control_q;
            ADDRESS_WIDTH'(REG_STATUS):      rd_mux = status;
`ifdef UP_REG_BANK_IRQ_EN
            ADDRESS_WIDTH'(REG_IRQ_PENDING): rd_mux = DATA_W'(irq_pending);
            ADDRESS_WIDTH'(REG_IRQ_ENABLE):  rd_mux = DATA_W'(irq_enable);
`endif
            default:                         rd_mux = '0;
        endcase
    end

    // Reset takes priority, so a request on a reset edge is dropped without ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_rack   <= 1'b0;
            up_rdata  <= '0;
            up_wack   <= 1'b0;
            scratch_q <= '0;
            control_q <= '0;
        end else begin
            up_rack  <= rd_acc;
            up_rdata <= rd_acc ? rd_mux : '0;
            up_wack  <= wr_acc;
            if (wr_acc && (w_idx == ADDRESS_WIDTH'(REG_SCRATCH))) begin
                scratch_q <= up_wdata;
            end
            if (wr_acc && (w_idx == ADDRESS_WIDTH'(REG_CONTROL))) begin
                control_q <= up_wdata;
            end
        end
    end

endmodule

// File: tb/tb_up_reg_bank.sv
// Directed self-checking bench for up_reg_bank; expectations adapt to whether
// UP_REG_BANK_IRQ_EN is defined for the build.
module tb_up_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_rreq;
    logic        up_rack;
    logic [15:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_wreq;
    logic        up_wack;
    logic [15:0] up_waddr;
    logic [31:0] up_wdata;
    logic [31:0] ctrl;
    logic [31:0] status;
    logic [7:0]  irq_src;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] STATUS_VAL = 32'h1234_5678;

    up_reg_bank dut (
        .clk      (clk),
        .rst      (rst),
        .up_rreq  (up_rreq),
        .up_rack  (up_rack),
        .up_raddr (up_raddr),
        .up_rdata (up_rdata),
        .up_wreq  (up_wreq),
        .up_wack  (up_wack),
        .up_waddr (up_waddr),
        .up_wdata (up_wdata),
        .ctrl     (ctrl),
        .status   (status),
        .irq_src  (irq_src),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp, input string tag);
        up_rreq  = 1'b1;
        up_raddr = addr;
        tick();
        check({tag, "_rack"}, {31'b0, up_rack}, 32'd1);
        check({tag, "_rdata"}, up_rdata, exp);
        up_rreq = 1'b0;
        tick();
        check({tag, "_rack_off"}, {31'b0, up_rack}, 32'd0);
        check({tag, "_rdata_off"}, up_rdata, 32'd0);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input string tag);
        up_wreq  = 1'b1;
        up_waddr = addr;
        up_wdata = data;
        tick();
        check({tag, "_wack"}, {31'b0, up_wack}, 32'd1);
        up_wreq = 1'b0;
        tick();
        check({tag, "_wack_off"}, {31'b0, up_wack}, 32'd0);
    endtask

    initial begin
        logic [5:0] rack_pattern;

        rst      = 1'b1;
        up_rreq  = 1'b0;
        up_raddr = '0;
        up_wreq  = 1'b0;
        up_waddr = '0;
        up_wdata = '0;
        status   = STATUS_VAL;
        irq_src  = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_rack", {31'b0, up_rack}, 32'd0);
        check("rst_wack", {31'b0, up_wack}, 32'd0);
        check("rst_rdata", up_rdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_ctrl", ctrl, 32'd0);

        do_read(16'h0000, 32'h0000_0001, "rd_id");
        do_read(16'h0008, 32'h0000_0000, "rd_ctrl_rst");
        do_read(16'h0004, 32'h0000_0000, "rd_scratch_rst");

        do_write(16'h0004, 32'hA5A5_5A5A, "wr_scratch");
        do_read(16'h0004, 32'hA5A5_5A5A, "rd_scratch");
        do_read(16'h0006, 32'hA5A5_5A5A, "rd_scratch_unaligned");

        // CONTROL must change exactly when the ack appears.
        up_wreq  = 1'b1;
        up_waddr = 16'h0008;
        up_wdata = 32'h0000_00FF;
        check("ctrl_before_wack", ctrl, 32'd0);
        tick();
        check("ctrl_wack", {31'b0, up_wack}, 32'd1);
        check("ctrl_with_wack", ctrl, 32'h0000_00FF);
        up_wreq = 1'b0;
        tick();
        do_read(16'h0008, 32'h0000_00FF, "rd_ctrl");

        // Sustained read: ack on every second cycle.
        up_rreq      = 1'b1;
        up_raddr     = 16'h0000;
        rack_pattern = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            rack_pattern = {rack_pattern[4:0], up_rack};
        end
        up_rreq = 1'b0;
        tick();
        check("sustained_rack_pattern", {26'b0, rack_pattern}, 32'h0000_002A);
        check("sustained_rack_idle", {31'b0, up_rack}, 32'd0);

        do_write(16'h000C, 32'hDEAD_BEEF, "wr_status_ro");
        do_read(16'h000C, STATUS_VAL, "rd_status");
        do_write(16'h0040, 32'hFFFF_FFFF, "wr_unmapped");
        do_read(16'h0040, 32'h0000_0000, "rd_unmapped");
        do_read(16'h0018, 32'h0000_0000, "rd_unmapped_18");

        // Simultaneous read and write to SCRATCH: read sees the old value.
        up_rreq  = 1'b1;
        up_raddr = 16'h0004;
        up_wreq  = 1'b1;
        up_waddr = 16'h0004;
        up_wdata = 32'h1111_2222;
        tick();
        check("rw_same_rack", {31'b0, up_rack}, 32'd1);
        check("rw_same_wack", {31'b0, up_wack}, 32'd1);
        check("rw_same_rdata", up_rdata, 32'hA5A5_5A5A);
        up_rreq = 1'b0;
        up_wreq = 1'b0;
        tick();
        do_read(16'h0004, 32'h1111_2222, "rd_after_rw");

`ifdef UP_REG_BANK_IRQ_EN
        do_write(16'h0014, 32'hFFFF_FF01, "wr_irq_en");
        do_read(16'h0014, 32'h0000_0001, "rd_irq_en");

        irq_src = 8'h01;
        tick();
        check("irq_src0_edge_n", {31'b0, irq}, 32'd0);
        tick();
        check("irq_src0_edge_n1", {31'b0, irq}, 32'd1);
        irq_src = 8'h00;
        do_read(16'h0010, 32'h0000_0001, "rd_pend_src0");
        do_write(16'h0010, 32'h0000_0001, "w1c_src0");
        check("irq_after_w1c", {31'b0, irq}, 32'd0);
        do_read(16'h0010, 32'h0000_0000, "rd_pend_cleared");

        irq_src = 8'h02;
        tick();
        tick();
        tick();
        check("irq_src1_masked", {31'b0, irq}, 32'd0);
        irq_src = 8'h00;
        do_read(16'h0010, 32'h0000_0002, "rd_pend_src1");
        do_write(16'h0010, 32'h0000_0002, "w1c_src1");

        // Set pending bit 0, then clear it on the edge of a fresh rise.
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        up_wreq  = 1'b1;
        up_waddr = 16'h0010;
        up_wdata = 32'h0000_0001;
        irq_src  = 8'h01;
        tick();
        check("w1c_vs_set_wack", {31'b0, up_wack}, 32'd1);
        up_wreq = 1'b0;
        tick();
        check("w1c_vs_set_irq", {31'b0, irq}, 32'd1);
        do_read(16'h0010, 32'h0000_0001, "rd_pend_set_wins");
        irq_src = 8'h00;
        do_write(16'h0010, 32'h0000_0001, "w1c_final");
        do_read(16'h0010, 32'h0000_0000, "rd_pend_final");
`else
        do_write(16'h0014, 32'h0000_00FF, "wr_irq_en_absent");
        do_read(16'h0014, 32'h0000_0000, "rd_irq_en_absent");
        irq_src = 8'hFF;
        tick();
        tick();
        tick();
        check("irq_absent_high", {31'b0, irq}, 32'd0);
        irq_src = 8'h00;
        tick();
        check("irq_absent_low", {31'b0, irq}, 32'd0);
        do_read(16'h0010, 32'h0000_0000, "rd_pend_absent");
`endif

        // Reset on the request edge of a SCRATCH write: no ack, no update.
        do_write(16'h0008, 32'h0000_0033, "wr_ctrl_pre_rst");
        up_wreq  = 1'b1;
        up_waddr = 16'h0004;
        up_wdata = 32'hCAFE_F00D;
        rst      = 1'b1;
        tick();
        check("rst_mid_wack", {31'b0, up_wack}, 32'd0);
        up_wreq = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_wack_after", {31'b0, up_wack}, 32'd0);
        check("rst_mid_ctrl", ctrl, 32'd0);
        do_read(16'h0004, 32'h0000_0000, "rd_scratch_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_reg_bank.md
# up_reg_bank

Register bank slave on the uP request/acknowledge bus, the direct downstream consumer of the Wishbone-to-uP bridge's `up_rreq`/`up_waddr`/`up_wdata` outputs. It decodes byte addresses into a fixed map of identification, scratch, control, status and interrupt registers. It returns one acknowledge per request and drives a level interrupt to the processor. Throughput is one transfer per two clocks; one instance per peripheral.

## Interface
- `ADDRESS_WIDTH`, 16, uP byte-address width.
- `BUS_WIDTH`, 4, data bus width in bytes; register width is `BUS_WIDTH*8`.
- `ID_VALUE`, 32'h0000_0001, constant returned by the ID register.
- `IRQ_WIDTH`, 8, number of interrupt sources; range 1..`BUS_WIDTH*8`.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `up_rreq`  in  1  read request.
- `up_rack`  out  1  read acknowledge, one-cycle pulse.
- `up_raddr`  in  `ADDRESS_WIDTH`  read byte address.
- `up_rdata`  out  `BUS_WIDTH*8`  read data; valid only while `up_rack`=1, zero otherwise.
- `up_wreq`  in  1  write request.
- `up_wack`  out  1  write acknowledge, one-cycle pulse.
- `up_waddr`  in  `ADDRESS_WIDTH`  write byte address.
- `up_wdata`  in  `BUS_WIDTH*8`  write data, always a full word.
- `ctrl`  out  `BUS_WIDTH*8`  CONTROL register contents.
- `status`  in  `BUS_WIDTH*8`  live status, sampled into read data.
- `irq_src`  in  `IRQ_WIDTH`  interrupt sources, rising-edge sensitive.
- `irq`  out  1  registered interrupt request, level.

## Operation
- Word index = address >> clog2(`BUS_WIDTH`); address bits below the index are ignored.
- Register map (byte offsets for `BUS_WIDTH`=4):
  - 0x00 ID: RO, returns `ID_VALUE`.
  - 0x04 SCRATCH: RW.
  - 0x08 CONTROL: RW, drives `ctrl`.
  - 0x0C STATUS: RO, returns `status` sampled at the request edge.
  - 0x10 IRQ_PENDING: read returns pending bits; write-1-to-clear.
  - 0x14 IRQ_ENABLE: RW; only the low `IRQ_WIDTH` bits are implemented.
- Unmapped addresses read zero. Writes to unmapped or RO addresses are discarded but still acknowledged.
- Unimplemented register bits read zero.
- Request acceptance: a request is accepted when `req`=1 and its own ack is 0.
  - On acceptance the ack is set for exactly one cycle.
  - A request still asserted during the ack cycle is not a new request. This absorbs the upstream request that lingers one cycle after acknowledge.
  - Sustained `req` is acknowledged every second cycle.
- Read and write channels are independent. Simultaneous `up_rreq` and `up_wreq` are both accepted, and both acks pulse in the same cycle.
  - If both target the same register, the read returns the pre-write value.
- IRQ logic:
  - Previous-value register on `irq_src`; a 0→1 transition sets the pending bit.
  - Set and W1C of the same bit in the same cycle: set wins.
  - `irq` <= |(pending & enable).

## Timing
- Write: `up_wreq` high at edge N → register updated and `up_wack`=1 after edge N. `ctrl` reflects the new value in the same cycle as `up_wack`.
- Read: `up_rreq` high at edge N → `up_rack`=1 and `up_rdata` valid after edge N (latency 1).
- IRQ: `irq_src` rising between edges N-1 and N → pending set after N → `irq` after N+1. If enabled, `irq` rises 2 cycles after the source edge.
- Reset values:
  - `up_rack`, `up_wack`, `up_rdata`, `irq` = 0.
  - SCRATCH, CONTROL, IRQ_PENDING, IRQ_ENABLE = 0.
  - `irq_src` history = 0. A source already high at reset release therefore sets pending after the first clock.
- Reset asserted mid-transfer: any ack due is suppressed, no register is written, and the outstanding request is dropped. The upstream bridge resets on the same signal.

## Configuration
- `UP_REG_BANK_IRQ_EN` defined: full IRQ logic as above.
- `UP_REG_BANK_IRQ_EN` undefined:
  - Edge detect, pending and enable registers are not built.
  - 0x10 and 0x14 read zero, and writes to them are acked and discarded.
  - `irq` is tied 0 and `irq_src` is unused.

## Structure
- Package `up_reg_bank_pkg`: register word-index constants (`REG_ID`, `REG_SCRATCH`, `REG_CONTROL`, `REG_STATUS`, `REG_IRQ_PENDING`, `REG_IRQ_ENABLE`) and an `IRQ_WIDTH` range-check function.
- Sub-module `up_irq_ctrl`, instantiated only under `UP_REG_BANK_IRQ_EN`. It contains edge detect, pending, enable and `irq` generation. Interface: `irq_src`, W1C strobe and data, enable write strobe and data, pending and enable readback, `irq`.

## Test plan
- Reset, read 0x00 → `up_rack` one cycle after request, `up_rdata`=32'h0000_0001. Read 0x08 → 0.
- Write 0xA5A5_5A5A to 0x04, read back → 0xA5A5_5A5A. Write 0x0000_00FF to 0x08 → `ctrl`=0xFF coincident with `up_wack`.
- `up_rreq` held high 6 cycles → exactly 3 `up_rack` pulses on alternate cycles. Write to 0x0C and 0x40 → acked, read values unchanged (`status` and 0 respectively).
- Write IRQ_ENABLE=0x01, pulse `irq_src[0]` → `irq`=1 two cycles after the rise. Write 0x01 to 0x10 → pending=0, then `irq`=0. Pulse `irq_src[1]` → pending bit 1 set, `irq` stays 0.
- W1C of bit 0 on the same cycle as a new `irq_src[0]` rise → pending bit 0 remains 1.
- Assert `rst` on the request cycle of a write to 0x04 → no `up_wack`, SCRATCH=0 after reset. Build without `UP_REG_BANK_IRQ_EN` → 0x10 reads 0 and `irq` stays 0 under source pulses.
